// File: rtl/mem_arb_pkg.sv
// Shared sizing helpers and limits for the FIFO-order memory arbiter.
package mem_arb_pkg;

  localparam int unsigned MIN_REQ = 2;
  localparam int unsigned MAX_REQ = 8;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [MAX_REQ-1:0] onehot_lowest(input logic [MAX_REQ-1:0] v);
    return v & (~v + MAX_REQ'(1));
  endfunction

endpackage

// File: rtl/arb_req_queue.sv
// Circular FIFO of one-hot requester tags; pointers carry an extra wrap bit.
module arb_req_queue
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          head,
  output logic                      empty,
  output logic [ptr_w(DEPTH)-1:0]   count
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] entries [DEPTH];
  logic             full;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = entries[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (push) begin
        entries[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr                  <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Each requester holds at most one entry, so this only fires on a logic bug.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full)) else $error("arb_req_queue: push while full");
    end
  end

endmodule

// File: rtl/mem_arbiter_fifo.sv
// Arrival-order arbiter and memory bus mux for NUM_REQ requesters.
// Define MEM_ARB_TIMEOUT_EN to revoke grants held longer than TIMEOUT_CYCLES.
module mem_arbiter_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  output logic [NUM_REQ-1:0]           grant,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  input  logic [NUM_REQ-1:0]           req_rw,
  output logic                         mem_en,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic                         mem_rw,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count,
  output logic                         grant_revoked
);

  if (NUM_REQ < MIN_REQ || NUM_REQ > MAX_REQ || QUEUE_DEPTH < NUM_REQ ||
      (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("mem_arbiter_fifo: unsupported NUM_REQ/QUEUE_DEPTH/TIMEOUT_CYCLES");
  end

  logic [NUM_REQ-1:0] in_queue;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] push_data;
  logic [NUM_REQ-1:0] head;
  logic [NUM_REQ-1:0] clear_mask;
  logic               push;
  logic               pop;
  logic               empty;
  logic               rel;
  logic               issue_slot;
  logic               head_live;
  logic               skip;
  logic               expire;

  assign pending   = req & ~in_queue;
  assign push      = |pending;
  assign push_data = NUM_REQ'(onehot_lowest(MAX_REQ'(pending)));

  arb_req_queue #(
    .WIDTH (NUM_REQ),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .count     (queue_count)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] hold_cnt;

  // Idle cycles keep the counter at zero, so each new grant starts from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt      <= '0;
      grant_revoked <= 1'b0;
    end else begin
      hold_cnt      <= (grant == '0) ? '0 : hold_cnt + 1'b1;
      grant_revoked <= expire;
    end
  end

  assign expire = (|(req & grant)) && (hold_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign expire        = 1'b0;
  assign grant_revoked = 1'b0;
`endif

  // The granted entry stays at the head until release, so release pops it.
  assign rel        = (grant != '0) && (((req & grant) == '0) || expire);
  assign issue_slot = (grant == '0) && !empty;
  assign head_live  = |(head & req);
  assign skip       = issue_slot && !head_live;
  assign pop        = rel || skip;

  always_comb begin
    clear_mask = '0;
    if (rel) begin
      clear_mask = grant;
    end else if (skip) begin
      clear_mask = head;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant    <= '0;
      in_queue <= '0;
    end else begin
      in_queue <= (in_queue | push_data) & ~clear_mask;
      if (rel) begin
        grant <= '0;
      end else if (issue_slot && head_live) begin
        grant <= head;
      end
    end
  end

  assign mem_en = |grant;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rw    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mem_addr  = mem_addr  | req_addr[i*ADDR_W +: ADDR_W];
        mem_wdata = mem_wdata | req_wdata[i*DATA_W +: DATA_W];
        mem_rw    = mem_rw    | req_rw[i];
      end
    end
  end

endmodule
